// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers {PC, instruction} pairs from fetch and hands
// them to decode in order over valid/ready; a taken-branch flush empties it.
module if_id_queue #(
  parameter int N     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_F,
  input  logic [N-1:0]  pc_F,
  input  logic [31:0]   instr_F,
  output logic          ready_F,
  output logic          valid_D,
  output logic [N-1:0]  pc_D,
  output logic [31:0]   instr_D,
  input  logic          ready_D,
  input  logic          flush_D,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake decisions depend only on registered state (plus flush for
  // ready_F), so there is never a fetch-to-decode combinational path.
  assign ready_F = (count < CW'(DEPTH)) && !flush_D;
  assign valid_D = (count != '0);
  assign push    = valid_F && ready_F;
  assign pop     = valid_D && ready_D && !flush_D;

  assign pc_D    = valid_D ? pc_mem[rd_ptr]    : '0;
  assign instr_D = valid_D ? instr_mem[rd_ptr] : '0;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_D) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; stale contents are masked by valid_D.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_F;
      instr_mem[wr_ptr] <= instr_F;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int N     = 64;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_F;
  logic [N-1:0]  pc_F;
  logic [31:0]   instr_F;
  logic          ready_F;
  logic          valid_D;
  logic [N-1:0]  pc_D;
  logic [31:0]   instr_D;
  logic          ready_D;
  logic          flush_D;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        vf;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        rd;
    logic        fl;
    logic        e_rf;
    logic        e_vd;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic [1:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } entry_t;

  vec_t   tbl [18];
  entry_t q [$];

  if_id_queue #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_F (valid_F),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .ready_F (ready_F),
    .valid_D (valid_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .ready_D (ready_D),
    .flush_D (flush_D),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rf, input logic vd,
                          input logic [63:0] epc, input logic [31:0] eins,
                          input logic [1:0] ecnt);
    chk({tag, ".ready_F"}, 64'(ready_F), 64'(rf));
    chk({tag, ".valid_D"}, 64'(valid_D), 64'(vd));
    chk({tag, ".pc_D"},    pc_D,         epc);
    chk({tag, ".instr_D"}, 64'(instr_D), 64'(eins));
    chk({tag, ".count"},   64'(count),   64'(ecnt));
  endtask

  task automatic drive(input logic vf, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rd, input logic fl);
    valid_F = vf;
    pc_F    = pc;
    instr_F = ins;
    ready_D = rd;
    flush_D = fl;
    #1;
  endtask

  // Reference expectations straight from the queue contents.
  task automatic model_chk(input string tag);
    logic        rf;
    logic        vd;
    logic [63:0] epc;
    logic [31:0] eins;
    rf   = (q.size() < DEPTH) && !flush_D;
    vd   = (q.size() != 0);
    epc  = vd ? q[0].pc  : 64'h0;
    eins = vd ? q[0].ins : 32'h0;
    chk_outs(tag, rf, vd, epc, eins, 2'(q.size()));
  endtask

  // Clock edge plus the model's view of what that edge does.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_push = valid_F && (q.size() < DEPTH) && !flush_D;
    do_pop  = ready_D && (q.size() != 0) && !flush_D;
    @(posedge clk);
    if (flush_D) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{pc: pc_F, ins: instr_F});
    end
    #1;
  endtask

  initial begin
    // inputs, then pre-edge expected ready_F, valid_D, pc_D, instr_D, count
    tbl[0]  = '{1'b1, 64'h00, 32'h8B020020, 1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[1]  = '{1'b0, 64'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 64'h00, 32'h8B020020, 2'd1};
    tbl[2]  = '{1'b0, 64'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 64'h00, 32'h8B020020, 2'd1};
    tbl[3]  = '{1'b0, 64'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[4]  = '{1'b1, 64'h00, 32'hA1,       1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[5]  = '{1'b1, 64'h04, 32'hA2,       1'b0, 1'b0, 1'b1, 1'b1, 64'h00, 32'hA1,       2'd1};
    tbl[6]  = '{1'b1, 64'h08, 32'hA3,       1'b0, 1'b0, 1'b0, 1'b1, 64'h00, 32'hA1,       2'd2};
    tbl[7]  = '{1'b1, 64'h08, 32'hA3,       1'b1, 1'b0, 1'b0, 1'b1, 64'h00, 32'hA1,       2'd2};
    tbl[8]  = '{1'b1, 64'h08, 32'hA3,       1'b0, 1'b0, 1'b1, 1'b1, 64'h04, 32'hA2,       2'd1};
    tbl[9]  = '{1'b0, 64'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 64'h04, 32'hA2,       2'd2};
    tbl[10] = '{1'b0, 64'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 64'h08, 32'hA3,       2'd1};
    tbl[11] = '{1'b0, 64'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[12] = '{1'b1, 64'h10, 32'hB1,       1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[13] = '{1'b1, 64'h14, 32'hB2,       1'b0, 1'b0, 1'b1, 1'b1, 64'h10, 32'hB1,       2'd1};
    tbl[14] = '{1'b1, 64'h18, 32'hB3,       1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 32'hB1,       2'd2};
    tbl[15] = '{1'b1, 64'h40, 32'hB4,       1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};
    tbl[16] = '{1'b0, 64'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 32'hB4,       2'd1};
    tbl[17] = '{1'b0, 64'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h00, 32'h0,        2'd0};

    // Reset held with fetch offering: nothing may be captured.
    reset = 1'b0;
    drive(1'b1, 64'h100, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst.count",   64'(count),   64'h0);
    chk("rst.valid_D", 64'(valid_D), 64'h0);
    chk("rst.pc_D",    pc_D,         64'h0);
    chk("rst.instr_D", 64'(instr_D), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    chk("rst.ready_F", 64'(ready_F), 64'h1);
    @(posedge clk); #1;

    // Directed table: single entry, fill/stall, empty pop, flush.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].vf, tbl[i].pc, tbl[i].ins, tbl[i].rd, tbl[i].fl);
      chk_outs($sformatf("tbl%0d", i), tbl[i].e_rf, tbl[i].e_vd, tbl[i].e_pc,
               tbl[i].e_ins, tbl[i].e_cnt);
      tick();
    end

    // Streaming: ten back-to-back PCs, decode sees them in order without gaps.
    for (int i = 0; i < 11; i++) begin
      drive(i < 10, 64'(4 * i), 32'h9000 + 32'(i), 1'b1, 1'b0);
      if (i > 0) begin
        chk($sformatf("strm%0d.pc_D", i),  pc_D,         64'(4 * (i - 1)));
        chk($sformatf("strm%0d.count", i), 64'(count),   64'h1);
      end
      model_chk($sformatf("strm%0d", i));
      tick();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    model_chk("strm_end");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom(), $urandom()}, $urandom(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      model_chk($sformatf("rnd%0d", i));
      tick();
    end

    // Asynchronous reset mid-cycle with two entries queued.
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h200, 32'hC1, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h204, 32'hC2, 1'b0, 1'b0); tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    chk("arst.pre_count", 64'(count), 64'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.count",   64'(count),   64'h0);
    chk("arst.valid_D", 64'(valid_D), 64'h0);
    chk("arst.pc_D",    pc_D,         64'h0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_chk("arst_rel");
    drive(1'b1, 64'h300, 32'hD1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    model_chk("arst_push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
